// File: rtl/ram_march_tester.sv
// Self-test sequencer for a single-port RAM with registered address/data/WE and unregistered Q.
// Writes an address-derived pattern to every word, then reads every word back and counts mismatches.
module ram_march_tester #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 2,
    parameter int unsigned NUM_WORDS = 16384
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Seed,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [15:0]       ErrCount,
    output logic [ADDR_W-1:0] FirstErrAddr,
    output logic [ADDR_W-1:0] RamAddress,
    output logic [DATA_W-1:0] RamData,
    output logic              RamWE,
    output logic              RamClockEn,
    input  logic [DATA_W-1:0] RamQ
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [15:0]       ERR_MAX   = '1;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] s);
        return DATA_W'(a) ^ s;
    endfunction

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_ce_q, ram_ce_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic                p0_valid_q, p0_valid_d;
    logic [ADDR_W-1:0]   p0_addr_q, p0_addr_d;
    logic [DATA_W-1:0]   p0_exp_q, p0_exp_d;
    logic                p1_valid_q;
    logic [ADDR_W-1:0]   p1_addr_q;
    logic [DATA_W-1:0]   p1_exp_q;

    logic                at_last;
    logic [ADDR_W-1:0]   addr_inc;

    assign at_last  = (ram_addr_q == LAST_ADDR);
    assign addr_inc = ram_addr_q + ADDR_W'(1);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (Start) state_d = S_WRITE;
            S_WRITE:        if (at_last) state_d = S_READ;
            S_READ:         if (at_last) state_d = S_DRAIN;
            S_DRAIN:        state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seed_d      = seed_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_we_d    = ram_we_q;
        ram_ce_d    = ram_ce_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;

        // Compare first so the DRAIN->DONE edge sees the final mismatch in Pass.
        if (p1_valid_q && (RamQ != p1_exp_q)) begin
            if (err_count_q != ERR_MAX) err_count_d = err_count_q + 16'd1;
            if (err_count_q == '0)      first_err_d = p1_addr_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    seed_d      = Seed;
                    err_count_d = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    ram_addr_d  = '0;
                    ram_data_d  = pat('0, Seed);
                    ram_we_d    = 1'b1;
                    ram_ce_d    = 1'b1;
                end
            end
            S_WRITE: begin
                if (at_last) begin
                    ram_addr_d = '0;
                    ram_we_d   = 1'b0;
                end else begin
                    ram_addr_d = addr_inc;
                    ram_data_d = pat(addr_inc, seed_q);
                end
            end
            S_READ: begin
                if (!at_last) ram_addr_d = addr_inc;
            end
            S_DRAIN: begin
                ram_ce_d = 1'b0;
                ram_we_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                pass_d   = (err_count_d == '0);
            end
            default: ;
        endcase

        p0_valid_d = (state_d == S_READ);
        p0_addr_d  = ram_addr_d;
        p0_exp_d   = pat(ram_addr_d, seed_d);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            seed_q      <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_ce_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            p0_valid_q  <= 1'b0;
            p0_addr_q   <= '0;
            p0_exp_q    <= '0;
            p1_valid_q  <= 1'b0;
            p1_addr_q   <= '0;
            p1_exp_q    <= '0;
        end else begin
            seed_q      <= seed_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_we_q    <= ram_we_d;
            ram_ce_q    <= ram_ce_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            p0_valid_q  <= p0_valid_d;
            p0_addr_q   <= p0_addr_d;
            p0_exp_q    <= p0_exp_d;
            p1_valid_q  <= p0_valid_q;
            p1_addr_q   <= p0_addr_q;
            p1_exp_q    <= p0_exp_q;
        end
    end

    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Pass         = pass_q;
    assign ErrCount     = err_count_q;
    assign FirstErrAddr = first_err_q;
    assign RamAddress   = ram_addr_q;
    assign RamData      = ram_data_q;
    assign RamWE        = ram_we_q;
    assign RamClockEn   = ram_ce_q;

endmodule

// File: tb/tb_ram_march_tester.sv
// Directed bench: a 4-word tester and a full 16K tester, each driving a behavioural RAM with
// selectable read faults (0 ideal, 1 bit0 stuck-at-0, 2 inverted).
module tb_ram_march_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-word instance
    logic        rst4_n, start4, busy4, done4, pass4, we4, ce4;
    logic [1:0]  seed4, data4, q4;
    logic [15:0] err4;
    logic [13:0] ferr4, addr4;
    logic [1:0]  mem4 [0:16383];
    logic [13:0] ra4 = '0;
    int          fault4 = 0;

    // full-size instance
    logic        rstf_n, startf, busyf, donef, passf, wef, cef;
    logic [1:0]  seedf, dataf, qf;
    logic [15:0] errf;
    logic [13:0] ferrf, addrf;
    logic [1:0]  memf [0:16383];
    logic [13:0] raf = '0;
    int          faultf = 0;

    ram_march_tester #(.ADDR_W(14), .DATA_W(2), .NUM_WORDS(4)) dut4 (
        .Clock(clk), .Reset(rst4_n), .Start(start4), .Seed(seed4),
        .Busy(busy4), .Done(done4), .Pass(pass4), .ErrCount(err4), .FirstErrAddr(ferr4),
        .RamAddress(addr4), .RamData(data4), .RamWE(we4), .RamClockEn(ce4), .RamQ(q4)
    );

    ram_march_tester #(.ADDR_W(14), .DATA_W(2), .NUM_WORDS(16384)) dutf (
        .Clock(clk), .Reset(rstf_n), .Start(startf), .Seed(seedf),
        .Busy(busyf), .Done(donef), .Pass(passf), .ErrCount(errf), .FirstErrAddr(ferrf),
        .RamAddress(addrf), .RamData(dataf), .RamWE(wef), .RamClockEn(cef), .RamQ(qf)
    );

    always @(posedge clk) begin
        if (ce4) begin
            ra4 <= addr4;
            if (we4) mem4[addr4] <= data4;
        end
        if (cef) begin
            raf <= addrf;
            if (wef) memf[addrf] <= dataf;
        end
    end

    assign q4 = (fault4 == 2) ? ~mem4[ra4] : (fault4 == 1) ? (mem4[ra4] & 2'b10) : mem4[ra4];
    assign qf = (faultf == 2) ? ~memf[raf] : (faultf == 1) ? (memf[raf] & 2'b10) : memf[raf];

    // Leaves the bench at the negedge just after the accepting edge E0.
    task automatic start4_run(input logic [1:0] s);
        @(negedge clk);
        seed4  = s;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic startf_run(input logic [1:0] s);
        @(negedge clk);
        seedf  = s;
        startf = 1'b1;
        @(negedge clk);
        startf = 1'b0;
    endtask

    // e = number of edges after E0 at which Done was first seen (bounded).
    task automatic wait4(output int e);
        e = 0;
        while (done4 !== 1'b1 && e < 64) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic waitf(output int e);
        e = 0;
        while (donef !== 1'b1 && e < 40000) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic test_reset();
        rst4_n = 1'b0; rstf_n = 1'b0;
        start4 = 1'b0; startf = 1'b0;
        seed4  = 2'b00; seedf = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy4, done4, pass4, we4, ce4, err4, ferr4, addr4, data4} !== 51'd0) begin
            errors++;
            $display("FAIL reset_state4: got %0h expected 0",
                     {busy4, done4, pass4, we4, ce4, err4, ferr4, addr4, data4});
        end
        checks++;
        if ({busyf, donef, passf, wef, cef, errf, ferrf, addrf, dataf} !== 51'd0) begin
            errors++;
            $display("FAIL reset_statef: got %0h expected 0",
                     {busyf, donef, passf, wef, cef, errf, ferrf, addrf, dataf});
        end
        rst4_n = 1'b1; rstf_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_write_read();
        logic [1:0] exp_w [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
        int e;
        fault4 = 0;
        start4_run(2'b01);
        checks++;
        if ({busy4, we4, ce4, addr4, data4} !== {3'b111, 14'd0, 2'd1}) begin
            errors++;
            $display("FAIL first_write: got %0h expected %0h",
                     {busy4, we4, ce4, addr4, data4}, {3'b111, 14'd0, 2'd1});
        end
        wait4(e);
        checks++;
        if (e !== 9) begin errors++; $display("FAIL done_edge4: got %0d expected 9", e); end
        checks++;
        if ({pass4, busy4, ce4, we4} !== 4'b1000) begin
            errors++; $display("FAIL done_flags4: got %b expected 1000", {pass4, busy4, ce4, we4});
        end
        checks++;
        if (err4 !== 16'd0 || ferr4 !== 14'd0) begin
            errors++; $display("FAIL ideal_counts: got err=%0d first=%0d expected 0 0", err4, ferr4);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem4[i] !== exp_w[i]) begin
                errors++; $display("FAIL pattern_seed1[%0d]: got %0d expected %0d", i, mem4[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_stuck_bit();
        int e;
        fault4 = 1;
        start4_run(2'b00);
        wait4(e);
        checks++;
        if (e !== 9) begin errors++; $display("FAIL stuck_done_edge: got %0d expected 9", e); end
        checks++;
        if (err4 !== 16'd2) begin errors++; $display("FAIL stuck_errcount: got %0d expected 2", err4); end
        checks++;
        if (ferr4 !== 14'd1) begin errors++; $display("FAIL stuck_first: got %0d expected 1", ferr4); end
        checks++;
        if (pass4 !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b expected 0", pass4); end
        fault4 = 0;
    endtask

    task automatic test_full_ideal();
        int e;
        faultf = 0;
        startf_run(2'b11);
        waitf(e);
        checks++;
        if (e !== 32769) begin errors++; $display("FAIL full_done_edge: got %0d expected 32769", e); end
        checks++;
        if ({passf, errf, ferrf} !== {1'b1, 16'd0, 14'd0}) begin
            errors++; $display("FAIL full_result: got pass=%b err=%0d first=%0d expected 1 0 0", passf, errf, ferrf);
        end
        checks++;
        if ({memf[0], memf[5], memf[16383]} !== {2'd3, 2'd2, 2'd0}) begin
            errors++; $display("FAIL full_pattern: got %0d %0d %0d expected 3 2 0", memf[0], memf[5], memf[16383]);
        end
    endtask

    task automatic test_reset_mid_run();
        int e;
        fault4 = 1;
        start4_run(2'b00);
        repeat (7) @(negedge clk);
        checks++;
        if ({busy4, err4} !== {1'b1, 16'd1}) begin
            errors++; $display("FAIL pre_reset: got busy=%b err=%0d expected 1 1", busy4, err4);
        end
        rst4_n = 1'b0;
        @(negedge clk);
        rst4_n = 1'b1;
        checks++;
        if ({busy4, done4, pass4, we4, ce4, err4, ferr4, addr4, data4} !== 51'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got %0h expected 0",
                     {busy4, done4, pass4, we4, ce4, err4, ferr4, addr4, data4});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy4, done4, we4, ce4} !== 4'b0000) begin
            errors++; $display("FAIL post_reset_idle: got %b expected 0000", {busy4, done4, we4, ce4});
        end
        fault4 = 0;
        start4_run(2'b01);
        wait4(e);
        checks++;
        if ({e == 9, pass4, err4} !== {1'b1, 1'b1, 16'd0}) begin
            errors++; $display("FAIL restart_after_reset: got edge=%0d pass=%b err=%0d expected 9 1 0", e, pass4, err4);
        end
    endtask

    task automatic test_start_while_busy();
        logic [1:0] exp_w [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        int e;
        fault4 = 0;
        start4_run(2'b10);
        e = 0;
        while (done4 !== 1'b1 && e < 64) begin
            @(negedge clk);
            e++;
            start4 = (e == 3 || e == 6);
            seed4  = 2'b01;
        end
        start4 = 1'b0;
        checks++;
        if (e !== 9) begin errors++; $display("FAIL busy_start_done_edge: got %0d expected 9", e); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem4[i] !== exp_w[i]) begin
                errors++; $display("FAIL busy_start_pattern[%0d]: got %0d expected %0d", i, mem4[i], exp_w[i]);
            end
        end
        // Leave errors behind, then hold Start high in DONE.
        fault4 = 1;
        start4_run(2'b00);
        wait4(e);
        fault4 = 0;
        seed4  = 2'b11;
        start4 = 1'b1;
        @(negedge clk);
        checks++;
        if ({done4, busy4, pass4, err4, ferr4} !== {3'b010, 16'd0, 14'd0}) begin
            errors++;
            $display("FAIL held_start_clear: got done=%b busy=%b pass=%b err=%0d first=%0d expected 0 1 0 0 0",
                     done4, busy4, pass4, err4, ferr4);
        end
        wait4(e);
        checks++;
        if ({e == 9, pass4} !== 2'b11) begin
            errors++; $display("FAIL held_start_run: got edge=%0d pass=%b expected 9 1", e, pass4);
        end
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if ({done4, busy4} !== 2'b01) begin
            errors++; $display("FAIL held_start_retrigger: got done=%b busy=%b expected 0 1", done4, busy4);
        end
        wait4(e);
        checks++;
        if ({e == 9, pass4} !== 2'b11) begin
            errors++; $display("FAIL retrigger_run: got edge=%0d pass=%b expected 9 1", e, pass4);
        end
    endtask

    task automatic test_error_count_saturation();
        int e;
        faultf = 2;
        startf_run(2'b00);
        waitf(e);
        checks++;
        if (e !== 32769) begin errors++; $display("FAIL inv_done_edge: got %0d expected 32769", e); end
        checks++;
        if ({errf, ferrf, passf} !== {16'd16384, 14'd0, 1'b0}) begin
            errors++; $display("FAIL inv_result: got err=%0d first=%0d pass=%b expected 16384 0 0", errf, ferrf, passf);
        end
        faultf = 0;
        fault4 = 2;
        start4_run(2'b00);
        force dut4.err_count_q = 16'hFFFE;
        #1;
        release dut4.err_count_q;
        wait4(e);
        checks++;
        if ({err4, pass4} !== {16'hFFFF, 1'b0}) begin
            errors++; $display("FAIL saturation: got err=%0h pass=%b expected ffff 0", err4, pass4);
        end
        fault4 = 0;
    endtask

    initial begin
        test_reset();
        test_basic_write_read();
        test_stuck_bit();
        test_full_ideal();
        test_reset_mid_run();
        test_start_while_busy();
        test_error_count_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
